egress_scheduler: RTL

Round-robin egress scheduler for one switch output port. It takes up to NUM_PORTS ingress requesters, each holding a parallel frame, and grants the shared TX serializer to one requester at a time. For each grant it issues a single-cycle load pulse and the frame, then holds off for the full shift window plus an inter-frame gap. It also screens out frames that lack a valid start bit.

---
 rtl/egress_scheduler.sv | 99 +++++++++
 1 files changed

// File: rtl/egress_scheduler.sv
// Round-robin egress scheduler: grants one requester at a time to the TX serializer,
// holds off for the shift window plus gap, and drops frames without a start bit.
module egress_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 16,
  parameter int GAP       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*DEPTH-1:0]    req_frame,
  output logic [NUM_PORTS-1:0]          req_ack,
  output logic [DEPTH-1:0]              tx_frame,
  output logic                          frame_tx_valid,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          busy,
  output logic [7:0]                    drop_cnt
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(DEPTH + GAP + 1);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [DEPTH-1:0] win_frame;

  // Rotating priority search starting just after the last granted port.
  always_comb begin
    int p;
    win_found = 1'b0;
    win_idx   = '0;
    p         = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      p = (int'(ptr) + k) % NUM_PORTS;
      if (!win_found && req_valid[p]) begin
        win_found = 1'b1;
        win_idx   = IW'(p);
      end
    end
    win_frame = req_frame[win_idx*DEPTH +: DEPTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ptr            <= IW'(NUM_PORTS - 1);
      cnt            <= '0;
      req_ack        <= '0;
      tx_frame       <= '0;
      frame_tx_valid <= 1'b0;
      grant_id       <= '0;
      busy           <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      req_ack        <= '0;
      frame_tx_valid <= 1'b0;
      case (state)
        IDLE: if (win_found) begin
          req_ack  <= ONE_HOT0 << win_idx;
          ptr      <= win_idx;
          grant_id <= win_idx;
          busy     <= 1'b1;
          if (!win_frame[DEPTH-1]) begin
            frame_tx_valid <= 1'b1;
            tx_frame       <= win_frame;
            cnt            <= CW'(DEPTH + GAP);
            state          <= SEND;
          end else begin
            // MSB set means no start bit: consume the frame without loading it.
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            state <= DROP;
          end
        end
        SEND: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DROP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
